// File: rtl/pneumatic_pkg.sv
// pneumatic_pkg
// Shared definitions for the three-cylinder pneumatic sequencer:
//   - state_t         : 3-bit sequencer state encoding
//   - VALVES_*        : {signal1, signal2, signal3} drive pattern per state
//   - *_DEFAULT       : default timing / counter-width parameters
//   - valve_decode()  : state -> valve pattern
//   - normal_next()   : successor state on an uninterrupted sequence
package pneumatic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXT1 = 3'd1,
        ST_EXT2 = 3'd2,
        ST_EXT3 = 3'd3,
        ST_HOLD = 3'd4,
        ST_RET3 = 3'd5,
        ST_RET2 = 3'd6,
        ST_RET1 = 3'd7
    } state_t;

    localparam logic [2:0] VALVES_IDLE = 3'b000;
    localparam logic [2:0] VALVES_EXT1 = 3'b100;
    localparam logic [2:0] VALVES_EXT2 = 3'b110;
    localparam logic [2:0] VALVES_EXT3 = 3'b111;
    localparam logic [2:0] VALVES_HOLD = 3'b111;
    localparam logic [2:0] VALVES_RET3 = 3'b110;
    localparam logic [2:0] VALVES_RET2 = 3'b100;
    localparam logic [2:0] VALVES_RET1 = 3'b000;

    localparam int STEP_CYCLES_DEFAULT = 50_000_000;
    localparam int HOLD_CYCLES_DEFAULT = 100_000_000;
    localparam int CNT_W_DEFAULT       = 27;

    function automatic logic [2:0] valve_decode(input state_t s);
        logic [2:0] v;
        case (s)
            ST_EXT1: v = VALVES_EXT1;
            ST_EXT2: v = VALVES_EXT2;
            ST_EXT3: v = VALVES_EXT3;
            ST_HOLD: v = VALVES_HOLD;
            ST_RET3: v = VALVES_RET3;
            ST_RET2: v = VALVES_RET2;
            ST_RET1: v = VALVES_RET1;
            default: v = VALVES_IDLE;
        endcase
        return v;
    endfunction

    function automatic state_t normal_next(input state_t s);
        state_t n;
        case (s)
            ST_EXT1: n = ST_EXT2;
            ST_EXT2: n = ST_EXT3;
            ST_EXT3: n = ST_HOLD;
            ST_HOLD: n = ST_RET3;
            ST_RET3: n = ST_RET2;
            ST_RET2: n = ST_RET1;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pneumatic_sync.sv
// pneumatic_sync
// Request-path conditioning: optional 2-flop synchroniser followed by a
// one-flop edge detector.
// Configuration macro: PNEU_SYNC_EN (defined -> 2-flop synchroniser on
// signalrasp; undefined -> signalrasp used directly, must be synchronous).
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   signalrasp in   request level from the Pi
//   rise       out  request rising edge (combinational, one cycle)
//   fall       out  request falling edge (combinational, one cycle)
module pneumatic_sync (
    input  logic clk,
    input  logic reset,
    input  logic signalrasp,
    output logic rise,
    output logic fall
);

    logic rasp_s;
    logic rasp_q_reg;

`ifdef PNEU_SYNC_EN
    logic [1:0] sync_reg;

    // Flops reset high so a request already asserted at reset release is
    // seen as a steady level, not as a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], signalrasp};
        end
    end

    assign rasp_s = sync_reg[1];
`else
    assign rasp_s = signalrasp;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rasp_q_reg <= 1'b1;
        end else begin
            rasp_q_reg <= rasp_s;
        end
    end

    assign rise = rasp_s & ~rasp_q_reg;
    assign fall = ~rasp_s & rasp_q_reg;

endmodule

// File: rtl/pneumatic_sequencer.sv
// pneumatic_sequencer
// Timed extend / hold / retract controller for three pneumatic valves.
// A request rising edge in IDLE runs EXT1..EXT3, HOLD, RET3..RET1; a request
// falling edge during extend/hold jumps to the matching retract step.
// Configuration macro: PNEU_SYNC_EN (see pneumatic_sync).
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   signalrasp in   request level from the Pi
//   signal1..3 out  valve drives, 1 = open
//   signal4    out  {signal1, signal2, signal3}
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse on completion after an abort
module pneumatic_sequencer
    import pneumatic_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signalrasp,
    output logic       signal1,
    output logic       signal2,
    output logic       signal3,
    output logic [2:0] signal4,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic rise;
    logic fall;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             abort_reg,   abort_next;
    logic             done_reg,    done_next;
    logic             aborted_reg, aborted_next;

    logic   can_abort;
    state_t abort_target;
    state_t succ;

    pneumatic_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .signalrasp (signalrasp),
        .rise       (rise),
        .fall       (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            abort_reg   <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            abort_reg   <= abort_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    // Abort retracts only the cylinders that have been extended so far.
    always_comb begin
        can_abort    = 1'b1;
        abort_target = ST_RET3;
        case (state_reg)
            ST_EXT1: abort_target = ST_RET1;
            ST_EXT2: abort_target = ST_RET2;
            ST_EXT3,
            ST_HOLD: abort_target = ST_RET3;
            default: can_abort    = 1'b0;
        endcase
    end

    assign succ = normal_next(state_reg);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        abort_next   = abort_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;

        if (state_reg == ST_IDLE) begin
            if (rise) begin
                state_next = ST_EXT1;
                cnt_next   = STEP_LOAD;
            end
        end else if (fall && can_abort) begin
            // Checked before the dwell expiry so an abort always wins.
            state_next = abort_target;
            cnt_next   = STEP_LOAD;
            abort_next = 1'b1;
        end else if (cnt_reg == '0) begin
            state_next = succ;
            if (succ == ST_HOLD) begin
                cnt_next = HOLD_LOAD;
            end else if (succ == ST_IDLE) begin
                cnt_next = '0;
            end else begin
                cnt_next = STEP_LOAD;
            end
            if (state_reg == ST_RET1) begin
                done_next    = ~abort_reg;
                aborted_next = abort_reg;
                abort_next   = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    assign {signal1, signal2, signal3} = valve_decode(state_reg);
    assign signal4 = valve_decode(state_reg);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign aborted = aborted_reg;

endmodule

// File: tb/tb_pneumatic_sequencer.sv
// tb_pneumatic_sequencer
// Directed bench for pneumatic_sequencer with STEP_CYCLES=4, HOLD_CYCLES=8.
// Expected valve patterns and pulse timing are hand-derived per cycle.
// Request latency is 1 edge without PNEU_SYNC_EN, 3 edges with it.
module tb_pneumatic_sequencer;

`ifdef PNEU_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       signalrasp = 1'b1;
    logic       signal1, signal2, signal3;
    logic [2:0] signal4;
    logic       busy, done, aborted;

    int n_tests = 0;
    int n_fail  = 0;

    pneumatic_sequencer #(
        .STEP_CYCLES (4),
        .HOLD_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signalrasp (signalrasp),
        .signal1    (signal1),
        .signal2    (signal2),
        .signal3    (signal3),
        .signal4    (signal4),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Valve pattern for cycle i of an uninterrupted 32-cycle sequence.
    function automatic logic [2:0] exp_valves(input int i);
        if (i < 4)       return 3'b100;
        else if (i < 8)  return 3'b110;
        else if (i < 20) return 3'b111;
        else if (i < 24) return 3'b110;
        else if (i < 28) return 3'b100;
        else             return 3'b000;
    endfunction

    task automatic settle_low();
        signalrasp = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    // Raise the request; returns in the first EXT1 cycle.
    task automatic start_seq();
        signalrasp = 1'b1;
        repeat (LAT - 1) tick();
        check("pre_latency_idle", {29'd0, signal4}, 32'd0);
        tick();
        check("latency_ext1", {29'd0, signal4}, 32'b100);
    endtask

    task automatic check_seq_cycle(input int i);
        check("seq_valves", {29'd0, signal4}, {29'd0, exp_valves(i)});
        check("seq_busy", {31'd0, busy}, 32'd1);
        check("seq_no_pulse", {30'd0, done, aborted}, 32'd0);
    endtask

    task automatic check_ret(input logic [2:0] v, input int n);
        for (int j = 0; j < n; j++) begin
            check("ret_valves", {29'd0, signal4}, {29'd0, v});
            check("ret_busy", {31'd0, busy}, 32'd1);
            tick();
        end
    endtask

    initial begin
        // Reset with request held high; release must not start a sequence.
        reset = 1'b0;
        signalrasp = 1'b1;
        repeat (3) tick();
        check("rst_outputs", {25'd0, signal1, signal2, signal3, signal4, busy}, 32'd0);
        check("rst_pulses", {30'd0, done, aborted}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            check("no_start_busy", {31'd0, busy}, 32'd0);
            check("no_start_valves", {29'd0, signal4}, 32'd0);
        end
        $display("[TB] reset-high-release scenario complete");

        // Full normal sequence.
        settle_low();
        start_seq();
        for (int i = 0; i < 32; i++) begin
            check_seq_cycle(i);
            tick();
        end
        check("normal_done", {31'd0, done}, 32'd1);
        check("normal_aborted", {31'd0, aborted}, 32'd0);
        check("normal_idle_busy", {31'd0, busy}, 32'd0);
        check("normal_bits", {29'd0, signal1, signal2, signal3}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_retrigger", {31'd0, busy}, 32'd0);
        end
        $display("[TB] normal sequence scenario complete");

        // Abort on the 2nd cycle of EXT2.
        settle_low();
        start_seq();
        repeat (5) tick();
        check("ext2_before_abort", {29'd0, signal4}, 32'b110);
        signalrasp = 1'b0;
        repeat (LAT) tick();
        check_ret(3'b100, 4);
        check_ret(3'b000, 4);
        check("ext2_abort_pulse", {31'd0, aborted}, 32'd1);
        check("ext2_abort_no_done", {31'd0, done}, 32'd0);
        check("ext2_abort_idle", {31'd0, busy}, 32'd0);
        tick();
        check("aborted_one_cycle", {31'd0, aborted}, 32'd0);
        $display("[TB] EXT2 abort scenario complete");

        // Drop lands on the last HOLD cycle (counter==0): abort must win.
        settle_low();
        start_seq();
        for (int i = 0; i < 20; i++) begin
            check_seq_cycle(i);
            if (i == 19 - (LAT - 1)) signalrasp = 1'b0;
            tick();
        end
        check_ret(3'b110, 4);
        check_ret(3'b100, 4);
        check_ret(3'b000, 4);
        check("hold_abort_pulse", {31'd0, aborted}, 32'd1);
        check("hold_abort_no_done", {31'd0, done}, 32'd0);
        $display("[TB] HOLD abort-vs-expiry scenario complete");

        // Request toggled during RET2 is ignored.
        settle_low();
        start_seq();
        for (int i = 0; i < 32; i++) begin
            check_seq_cycle(i);
            if (i == 25) signalrasp = 1'b0;
            if (i == 26) signalrasp = 1'b1;
            if (i == 27) signalrasp = 1'b0;
            tick();
        end
        check("toggle_done", {31'd0, done}, 32'd1);
        check("toggle_no_abort", {31'd0, aborted}, 32'd0);
        tick();
        check("toggle_idle", {31'd0, busy}, 32'd0);
        $display("[TB] RET2 toggle scenario complete");

        // Reset asserted in EXT3.
        settle_low();
        start_seq();
        repeat (9) tick();
        check("ext3_before_reset", {29'd0, signal4}, 32'b111);
        reset = 1'b0;
        #1;
        check("reset_valves_now", {29'd0, signal4}, 32'd0);
        check("reset_busy_now", {31'd0, busy}, 32'd0);
        tick();
        check("reset_no_pulse", {30'd0, done, aborted}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check("post_reset_idle", {29'd0, busy, done, aborted}, 32'd0);
        end
        $display("[TB] mid-sequence reset scenario complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pneumatic_sequencer.md
# pneumatic_sequencer

Timed controller for the three-cylinder pneumatic bank. A single request level from the Raspberry Pi triggers a fixed extend / hold / retract sequence: valves 1, 2 and 3 open in order, hold, then close in reverse order. Dropping the request aborts the sequence into a safe, ordered retraction. The block sits between the Pi GPIO input and the valve driver outputs.

## Interface
Parameters:
- STEP_CYCLES, 50_000_000: duration of each EXTn/RETn step in clk cycles; must be ≥1.
- HOLD_CYCLES, 100_000_000: duration of HOLD in clk cycles; must be ≥1.
- CNT_W, 27: dwell counter width; must hold max(STEP_CYCLES, HOLD_CYCLES)-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- signalrasp  in  1  request level from the Pi; may be asynchronous.
- signal1  out  1  valve 1 drive, 1 = open.
- signal2  out  1  valve 2 drive.
- signal3  out  1  valve 3 drive.
- signal4  out  3  {signal1, signal2, signal3}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on completion after an abort.

## Operation
- States: IDLE, EXT1, EXT2, EXT3, HOLD, RET3, RET2, RET1.
- Valve decode from state, {s1,s2,s3}:
  - IDLE 000, EXT1 100, EXT2 110, EXT3 111, HOLD 111.
  - RET3 110, RET2 100, RET1 000.
- Request path: rasp_s is the (optionally synchronised) input; rasp_q is rasp_s delayed one flop.
  - rise = rasp_s & ~rasp_q; fall = ~rasp_s & rasp_q.
- IDLE + rise: go to EXT1 and load the counter. A held-high level never retriggers; a new sequence needs a low-then-high.
- Rise outside IDLE is ignored.
- Counter loads N-1 on state entry and decrements each cycle. The state advances on the cycle the counter equals 0, so every state lasts exactly N cycles.
- Normal sequence: EXT1→EXT2→EXT3→HOLD→RET3→RET2→RET1→IDLE.
- Abort: fall in EXT1 jumps to RET1; in EXT2 to RET2; in EXT3 or HOLD to RET3. The counter reloads and a sticky abort flag is set.
  - Fall in RET3/RET2/RET1/IDLE has no effect.
- Fall and counter==0 in the same cycle: the abort wins.
- RET1 → IDLE: pulse done if the abort flag is clear, otherwise pulse aborted; then clear the flag.

## Timing
- Reset values:
  - State IDLE, counter 0, abort flag 0.
  - signal1..3, signal4, busy, done, aborted all 0.
  - Sync flops and rasp_q reset to 1, so a high signalrasp at reset release does not start a sequence.
- Outputs are decoded from registered state and change on the same edge as the state.
- Request latency: signal1 rises on the first clk edge that samples signalrasp high (macro off), or 2 edges later (macro on). Abort latency is identical.
- Normal sequence: busy for 6·STEP_CYCLES + HOLD_CYCLES cycles.
- done/aborted is registered: high in the first IDLE cycle only.
- Reset asserted mid-sequence: all valves close immediately and no pulse is issued.

## Configuration
- PNEU_SYNC_EN defined: rasp_s comes from a 2-flop synchroniser on signalrasp, adding 2 cycles of latency.
- PNEU_SYNC_EN undefined: rasp_s = signalrasp directly. Only valid when the input is already synchronous to clk.

## Structure
- pneumatic_pkg holds:
  - the state enum typedef (3 bits);
  - the per-state valve decode constants;
  - default parameter constants.
- Sub-module pneumatic_sync holds the optional synchroniser plus the rasp_q edge detector, and outputs rise/fall. The FSM and counter stay in pneumatic_sequencer.

## Test plan
Use STEP_CYCLES=4, HOLD_CYCLES=8.
- Reset with signalrasp held high, then release -> no sequence starts; all outputs 0.
- Drive low, then raise and hold high -> signal4 steps 100, 110, 111 (4 cycles each), 111 for 8 cycles, then 110, 100, 000 (4 each). busy is high for 32 cycles. done pulses once; no restart while the input stays high.
- Raise, then drop on the 2nd cycle of EXT2 -> RET2 (100) for 4 cycles, RET1 (000) for 4 cycles, then an aborted pulse; done stays 0.
- Drop during HOLD coincident with counter==0 -> enters RET3, not a normal advance; aborted pulses at the end.
- Toggle the request during RET2 -> ignored; sequence completes in the original timing.
- Assert reset in EXT3 -> signal4=000, busy=0 on the reset edge; no done/aborted pulse. Repeat the request latency check with and without PNEU_SYNC_EN (1 vs 3 edges).
